// File: rtl/xilinx_distram_pkg.sv
// xilinx_distram_pkg: shared constants, depth helper and read-mode enum for the distributed-RAM FIFO
package xilinx_distram_pkg;
  localparam int AW_MIN = 5;
  localparam int AW_MAX = 8;
  typedef enum logic {RD_STD, RD_FWFT} rd_mode_e;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/xilinx_sdp_distram.sv
// xilinx_sdp_distram: simple-dual-port LUT RAM, one 1-bit RAMnX1D-style column per data bit
module xilinx_sdp_distram
  import xilinx_distram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  WCLK,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WA,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [ADDR_WIDTH-1:0] RA,
  output logic [DATA_WIDTH-1:0] O
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_col
    logic [DEPTH-1:0] col_q;
    // synchronous write into this bit's column; read side is asynchronous
    always_ff @(posedge WCLK)
      if (WE) col_q[WA] <= D[b];
    assign O[b] = col_q[RA];
  end
endmodule

// File: rtl/xilinx_distram_fifo.sv
// xilinx_distram_fifo: single-clock FIFO on distributed LUT RAM with standard or first-word-fall-through reads
module xilinx_distram_fifo
  import xilinx_distram_pkg::*;
#(
  parameter int ADDR_WIDTH       = 6,
  parameter int DATA_WIDTH       = 8,
  parameter int FWFT             = 0,
  parameter int PROG_FULL_THRESH = depth_of(ADDR_WIDTH) - 4
) (
  input  logic                  WCLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic                  FULL,
  output logic                  PROG_FULL,
  output logic                  OVERFLOW,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  EMPTY,
  output logic                  VALID,
  output logic                  UNDERFLOW,
  output logic [ADDR_WIDTH:0]   COUNT
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STD;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PF_TH = (ADDR_WIDTH+1)'(PROG_FULL_THRESH);
  if (ADDR_WIDTH < AW_MIN || ADDR_WIDTH > AW_MAX) begin : g_bad_aw
    $error("xilinx_distram_fifo: ADDR_WIDTH must be 5..8");
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_bad_pf
    $error("xilinx_distram_fifo: PROG_FULL_THRESH must be 1..DEPTH");
  end
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, ram_o;
  logic ovalid_q, ovalid_d, valid_q, valid_d, empty_q, empty_d;
  logic full_q, prog_full_q, overflow_q, underflow_q;
  logic wr_acc, pop;
  xilinx_sdp_distram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .WCLK (WCLK),
    .WE   (wr_acc && !RST),
    .WA   (wr_ptr_q),
    .D    (DIN),
    .RA   (rd_ptr_q),
    .O    (ram_o)
  );
  // pop moves the RAM head into DOUT: on an accepted read (standard) or a prefetch (FWFT)
  always_comb begin
    wr_acc    = WR_EN && !full_q;
    pop       = (MODE == RD_FWFT) ? (ram_cnt_q != '0) && (!ovalid_q || RD_EN) : RD_EN && !empty_q;
    ovalid_d  = (MODE == RD_FWFT) && (pop || (ovalid_q && !RD_EN));
    ram_cnt_d = ram_cnt_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(pop);
    count_d   = ram_cnt_d + (ADDR_WIDTH+1)'(ovalid_d);
    dout_d    = pop ? ram_o : dout_q;
    valid_d   = (MODE == RD_FWFT) ? ovalid_d : pop;
    empty_d   = (MODE == RD_FWFT) ? !ovalid_d : (ram_cnt_d == '0);
  end
  // state and registered flags; flags come from next-state so they track the same edge
  always_ff @(posedge WCLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      count_q     <= '0;
      ovalid_q    <= 1'b0;
      valid_q     <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      prog_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_q + ADDR_WIDTH'(wr_acc);
      rd_ptr_q    <= rd_ptr_q + ADDR_WIDTH'(pop);
      ram_cnt_q   <= ram_cnt_d;
      count_q     <= count_d;
      ovalid_q    <= ovalid_d;
      valid_q     <= valid_d;
      empty_q     <= empty_d;
      full_q      <= ram_cnt_d == FULL_CNT;
      prog_full_q <= count_d >= PF_TH;
      overflow_q  <= WR_EN && full_q;
      underflow_q <= RD_EN && empty_q;
      dout_q      <= dout_d;
    end
  end
  assign FULL      = full_q;
  assign PROG_FULL = prog_full_q;
  assign OVERFLOW  = overflow_q;
  assign DOUT      = dout_q;
  assign EMPTY     = empty_q;
  assign VALID     = valid_q;
  assign UNDERFLOW = underflow_q;
  assign COUNT     = count_q;
endmodule

// File: tb/tb_xilinx_distram_fifo.sv
// tb_xilinx_distram_fifo: standard and FWFT instances driven together against queue reference models
module tb_xilinx_distram_fifo;
  localparam int DEPTH = 32;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0;
  logic s_full, s_pf, s_ovf, s_empty, s_valid, s_unf, f_full, f_pf, f_ovf, f_empty, f_valid, f_unf;
  logic [7:0] s_dout, f_dout;
  logic [5:0] s_count, f_count;
  int checks = 0, failures = 0;
  logic [7:0] sq[$], fq[$];
  logic [7:0] sd = '0, fd = '0;
  logic fhv = 1'b0;
  always #5 clk = ~clk;
  xilinx_distram_fifo #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .FWFT(0)) u_std (
    .WCLK(clk), .RST(rst), .WR_EN(wr_en), .DIN(din), .FULL(s_full), .PROG_FULL(s_pf),
    .OVERFLOW(s_ovf), .RD_EN(rd_en), .DOUT(s_dout), .EMPTY(s_empty), .VALID(s_valid),
    .UNDERFLOW(s_unf), .COUNT(s_count));
  xilinx_distram_fifo #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .FWFT(1)) u_fwft (
    .WCLK(clk), .RST(rst), .WR_EN(wr_en), .DIN(din), .FULL(f_full), .PROG_FULL(f_pf),
    .OVERFLOW(f_ovf), .RD_EN(rd_en), .DOUT(f_dout), .EMPTY(f_empty), .VALID(f_valid),
    .UNDERFLOW(f_unf), .COUNT(f_count));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rs);
    logic s_ovf_e, s_unf_e, s_val_e, f_ovf_e, f_unf_e, f_pop;
    int fc;
    rst = rs; wr_en = w; din = d; rd_en = r;
    if (rs) begin
      sq.delete(); fq.delete();
      sd = '0; fd = '0; fhv = 1'b0;
      s_ovf_e = 0; s_unf_e = 0; s_val_e = 0; f_ovf_e = 0; f_unf_e = 0;
    end else begin
      s_ovf_e = w && sq.size() == DEPTH;
      s_unf_e = r && sq.size() == 0;
      s_val_e = r && sq.size() != 0;
      if (s_val_e) sd = sq.pop_front();
      if (w && !s_ovf_e) sq.push_back(d);
      f_ovf_e = w && fq.size() == DEPTH;
      f_unf_e = r && !fhv;
      f_pop = fq.size() != 0 && (!fhv || r);
      if (f_pop) begin
        fd = fq.pop_front();
        fhv = 1'b1;
      end else if (r) fhv = 1'b0;
      if (w && !f_ovf_e) fq.push_back(d);
    end
    @(posedge clk); #1;
    fc = fq.size() + int'(fhv);
    chk("s_dout", s_dout, sd);
    chk("s_valid", s_valid, s_val_e);
    chk("s_empty", s_empty, sq.size() == 0);
    chk("s_full", s_full, sq.size() == DEPTH);
    chk("s_prog_full", s_pf, sq.size() >= 28);
    chk("s_count", s_count, sq.size());
    chk("s_overflow", s_ovf, s_ovf_e);
    chk("s_underflow", s_unf, s_unf_e);
    chk("f_dout", f_dout, fd);
    chk("f_valid", f_valid, fhv);
    chk("f_empty", f_empty, !fhv);
    chk("f_full", f_full, fq.size() == DEPTH);
    chk("f_prog_full", f_pf, fc >= 28);
    chk("f_count", f_count, fc);
    chk("f_overflow", f_ovf, f_ovf_e);
    chk("f_underflow", f_unf, f_unf_e);
  endtask
  initial begin
    #1;
    step(1, 8'h55, 1, 1);
    step(0, 0, 0, 1);
    chk("rst_s_empty", s_empty, 1);
    chk("rst_f_empty", f_empty, 1);
    for (int i = 0; i < 8; i++) step(1, 8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("seq_s_last", s_dout, 8'h17);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("unf_s_hold", s_dout, 8'h17);
    step(1, 8'hA5, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("fwft_fall", f_dout, 8'hA5);
    chk("fwft_valid", f_valid, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 8'hB0 + 8'(i), 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 34; i++) step(1, 8'($urandom), 0, 0);
    chk("fill_s_count", s_count, 32);
    chk("fill_f_count", f_count, 33);
    chk("fill_s_full", s_full, 1);
    step(1, 8'hEE, 1, 0);
    chk("ovf_s_count", s_count, 31);
    chk("ovf_s_pulse", s_ovf, 1);
    for (int i = 0; i < 36; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 100; i++) step(1, 8'($urandom), 1, 0);
    chk("wrap_s_count", s_count, 5);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 99) < (i < 150 ? 70 : 35)) ? 1'b1 : 1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0);
    step(1, 8'h77, 1, 1);
    chk("mid_rst_s_count", s_count, 0);
    chk("mid_rst_f_dout", f_dout, 0);
    step(1, 8'hC3, 0, 0);
    step(0, 0, 1, 0);
    chk("post_rst_s_dout", s_dout, 8'hC3);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
